// File: rtl/minsec_button_conditioner_if.sv
// Button bundle between the pads/consumers and minsec_button_conditioner:
// raw pad levels in, debounced levels and press ticks out.
interface minsec_button_conditioner_if;
    logic btnU_raw;
    logic btnC_raw;
    logic btnD_raw;
    logic btnU;
    logic btnC;
    logic btnD;
    logic btnU_tick;
    logic btnC_tick;
    logic btnD_tick;

    // Master drives the pads and consumes the conditioned outputs
    modport master (
        output btnU_raw, btnC_raw, btnD_raw,
        input  btnU, btnC, btnD,
        input  btnU_tick, btnC_tick, btnD_tick
    );

    modport slave (
        input  btnU_raw, btnC_raw, btnD_raw,
        output btnU, btnC, btnD,
        output btnU_tick, btnC_tick, btnD_tick
    );
endinterface

// File: rtl/minsec_button_conditioner.sv
// Synchronise, debounce and tick-generate the three stopwatch buttons (U, C, D).
// Define MINSEC_BTN_AUTO_REPEAT_EN to add held-button auto-repeat ticks on U and D.
module minsec_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input logic                        clk,
    input logic                        reset_n,
    minsec_button_conditioner_if.slave btn
);
    localparam logic [25:0] DebLast = 26'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_t;

    logic [2:0] raw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] level;
    logic [2:0] tick;

    // Channel index order: 0 = U, 1 = C, 2 = D
    assign raw = {btn.btnD_raw, btn.btnC_raw, btn.btnU_raw};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        state_t      state_q, state_d;
        logic [25:0] cnt_q, cnt_d;
        logic        level_q, level_d;
        logic        tick_q, tick_d;
        logic        rpt_fire;
        logic        s2;

        assign s2 = sync2_q[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            tick_d  = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (s2) begin
                        state_d = StPressWait;
                        cnt_d   = 26'd1;
                    end
                end
                StPressWait: begin
                    if (!s2) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == DebLast) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                        tick_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 26'd1;
                    end
                end
                StPressed: begin
                    if (!s2) begin
                        state_d = StReleaseWait;
                        cnt_d   = 26'd1;
                    end
                end
                StReleaseWait: begin
                    if (s2) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else if (cnt_q == DebLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 26'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
            level_d = (state_d == StPressed) || (state_d == StReleaseWait);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                level_q <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                tick_q  <= tick_d | rpt_fire;
            end
        end

`ifdef MINSEC_BTN_AUTO_REPEAT_EN
        localparam bit          RptEn   = (i != 1);
        localparam logic [25:0] DlyLast = 26'(REPEAT_DELAY - 1);
        localparam logic [25:0] PerLast = 26'(REPEAT_PERIOD - 1);

        logic [25:0] rpt_cnt_q, rpt_cnt_d;
        logic        rpt_armed_q, rpt_armed_d;

        // Counter runs only while the channel stays in PRESSED; armed selects
        // the initial delay versus the steady repeat period.
        always_comb begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
            rpt_fire    = 1'b0;
            if (RptEn && (state_q == StPressed) && (state_d == StPressed)) begin
                rpt_cnt_d   = rpt_cnt_q + 26'd1;
                rpt_armed_d = rpt_armed_q;
                if (rpt_cnt_q == (rpt_armed_q ? PerLast : DlyLast)) begin
                    rpt_fire    = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_armed_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rpt_cnt_q   <= '0;
                rpt_armed_q <= 1'b0;
            end else begin
                rpt_cnt_q   <= rpt_cnt_d;
                rpt_armed_q <= rpt_armed_d;
            end
        end
`else
        assign rpt_fire = 1'b0;
`endif

        assign level[i] = level_q;
        assign tick[i]  = tick_q;
    end

    assign btn.btnU      = level[0];
    assign btn.btnC      = level[1];
    assign btn.btnD      = level[2];
    assign btn.btnU_tick = tick[0];
    assign btn.btnC_tick = tick[1];
    assign btn.btnD_tick = tick[2];
endmodule

// File: tb/tb_minsec_button_conditioner.sv
// Directed bench for minsec_button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_PERIOD=8; expectations follow MINSEC_BTN_AUTO_REPEAT_EN.
module tb_minsec_button_conditioner;
`ifdef MINSEC_BTN_AUTO_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    minsec_button_conditioner_if bif ();

    minsec_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .btn    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    // Tick expected at press edge t, plus repeat ticks when auto-repeat is built in
    function automatic logic exp_rpt(input int k, input int t);
        return (k == t) || (RPT && (k >= t + 20) && (((k - t - 20) % 8) == 0));
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_u"}, 0, bif.btnU, 1'b0);
        chk({tag, "_c"}, 0, bif.btnC, 1'b0);
        chk({tag, "_d"}, 0, bif.btnD, 1'b0);
        chk({tag, "_ut"}, 0, bif.btnU_tick, 1'b0);
        chk({tag, "_ct"}, 0, bif.btnC_tick, 1'b0);
        chk({tag, "_dt"}, 0, bif.btnD_tick, 1'b0);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset_n      = 1'b0;
        bif.btnU_raw = 1'b0;
        bif.btnC_raw = 1'b0;
        bif.btnD_raw = 1'b0;

        // Reset state
        idle(3);
        chk_all_zero("reset");
        reset_n = 1'b1;
        idle(3);

        // Clean press and release on U; raw changes just after edge 0
        bif.btnU_raw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk("clean_u_tick", k, bif.btnU_tick, exp_rpt(k, 6));
            chk("clean_u_lvl", k, bif.btnU, k >= 6);
        end
        bif.btnU_raw = 1'b0;
        for (int k = 31; k <= 40; k++) begin
            @(negedge clk);
            chk("rel_u_tick", k, bif.btnU_tick, 1'b0);
            chk("rel_u_lvl", k, bif.btnU, k < 36);
        end
        idle(4);

        // Bounce on C: high 3, low 1, then held; final rise after edge 4
        bif.btnC_raw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            chk("bounce_c_tick", k, bif.btnC_tick, k == 10);
            chk("bounce_c_lvl", k, bif.btnC, k >= 10);
            if (k == 3) bif.btnC_raw = 1'b0;
            if (k == 4) bif.btnC_raw = 1'b1;
        end
        // Two-cycle low glitch while pressed
        bif.btnC_raw = 1'b0;
        for (int k = 15; k <= 24; k++) begin
            @(negedge clk);
            if (k == 16) bif.btnC_raw = 1'b1;
            chk("glitch_c_tick", k, bif.btnC_tick, 1'b0);
            chk("glitch_c_lvl", k, bif.btnC, 1'b1);
        end
        bif.btnC_raw = 1'b0;
        idle(10);
        chk("c_released", 0, bif.btnC, 1'b0);

        // Simultaneous U, C, D press held long enough to see auto-repeat
        bif.btnU_raw = 1'b1;
        bif.btnC_raw = 1'b1;
        bif.btnD_raw = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            chk("sim_u_tick", k, bif.btnU_tick, exp_rpt(k, 6));
            chk("sim_d_tick", k, bif.btnD_tick, exp_rpt(k, 6));
            chk("sim_c_tick", k, bif.btnC_tick, k == 6);
        end
        bif.btnU_raw = 1'b0;
        bif.btnC_raw = 1'b0;
        bif.btnD_raw = 1'b0;
        idle(10);
        chk_all_zero("sim_released");

        // Reset during PRESS_WAIT on U
        bif.btnU_raw = 1'b1;
        idle(4);
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_pw");
        idle(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("rst_pw_u_tick", k, bif.btnU_tick, k == 6);
            chk("rst_pw_u_lvl", k, bif.btnU, k >= 6);
        end
        // Reset during PRESSED: level must drop without waiting for a clock
        reset_n = 1'b0;
        #1;
        chk("rst_pr_u_lvl", 0, bif.btnU, 1'b0);
        chk_all_zero("rst_pr");
        idle(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("rst_pr_u_tick", k, bif.btnU_tick, k == 6);
            chk("rst_pr_u_lvl", k, bif.btnU, k >= 6);
        end
        bif.btnU_raw = 1'b0;
        idle(10);
        chk("u_final", 0, bif.btnU, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
